poly_eval_stream: RTL and testbench
===================================

Name: poly_eval_stream

Overview:
- Parametrised polynomial evaluator: computes P(x) = c_n*x^n + ... + c_1*x + c_0 for runtime degree n <= MAX_DEGREE, at WIDTH-bit precision.
- Successor to the fixed 8-bit, 2nd-order, push-button evaluator. Replaces the go-button loading with valid/ready streaming, evaluates by Horner's rule (one multiply-accumulate per accepted coefficient) and adds overflow reporting.
- Sits between a switch/stream source and the HEX/LED display logic on the lab board top level.

Parameters:
- WIDTH, 8, data, coefficient and result width in bits.
- MAX_DEGREE, 3, highest supported polynomial degree (>= 0).
- DW, $clog2(MAX_DEGREE+1) (min 1), width of the degree field; derived, not overridden.

Ports:
- clk  in  1  clock.
- resetn  in  1  synchronous active-low reset.
- in_valid  in  1  in_data/in_degree beat valid.
- in_ready  out  1  block accepts a beat this cycle.
- in_data  in  WIDTH  first beat: x; subsequent beats: coefficients, highest order first.
- in_degree  in  DW  polynomial degree; sampled only on the x beat.
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts the result.
- out_result  out  WIDTH  P(x) mod 2^WIDTH.
- out_overflow  out  1  some intermediate value exceeded WIDTH bits.
- busy  out  1  high in any state other than S_IDLE.

Behaviour:
- Reset is resetn, synchronous, active-low; clock is clk. Reset is sampled on posedge clk.
- Reset values: state=S_IDLE, in_ready=1, out_valid=0, out_result=0, out_overflow=0, busy=0. The internal acc, x_reg, count and ovf registers are 0.
- A beat is accepted when in_valid && in_ready at a posedge. No combinational path runs from in_valid or out_ready to any output.
- S_IDLE (in_ready=1):
  - On accept: x_reg<=in_data; deg<=min(in_degree, MAX_DEGREE); count<=0; acc<=0; ovf<=0.
  - Then go to S_COEF.
- S_COEF (in_ready=1):
  - On accept: {hi, lo} = acc*x_reg + in_data, computed at 2*WIDTH+1 bits; acc<=lo; ovf<=ovf | (hi!=0).
  - If count==deg, go to S_DONE, else count<=count+1.
  - No accept: hold all registers; gaps of any length are legal.
- Multiply-step rule: on the first coefficient acc=0, so acc becomes c_n exactly. Overflow is judged per step on the wrapped acc.
- S_DONE (in_ready=0, out_valid=1):
  - out_result=acc and out_overflow=ovf, both held stable while out_valid && !out_ready.
  - On out_ready: go to S_IDLE, so out_valid=0 and in_ready=1 on the next cycle.
  - in_valid is ignored in S_DONE.
- Latency: out_valid rises on the cycle after the last coefficient is accepted. A full evaluation takes n+2 accepted beats plus one cycle.
- Throughput: one result per (n+2) input beats plus one cycle, given no backpressure.
- Degree 0: x beat, then a single coefficient c_0. Result is c_0 and overflow is 0.
- Degree field > MAX_DEGREE: clamped to MAX_DEGREE. Excess coefficients are not consumed and belong to the next transaction.
- Reset mid-operation (S_COEF or S_DONE): the partial result is discarded, the block returns to S_IDLE and out_valid drops the next cycle.
- in_valid and out_ready may be asserted simultaneously in S_DONE. Only the output handshake completes; the input beat must be re-presented.

Decomposition:
- Package poly_eval_pkg:
  - state encoding S_IDLE, S_COEF, S_DONE (2 bits);
  - DW derivation function;
  - a clamp-degree function.
- Sub-module horner_step, purely combinational:
  - inputs: acc, x, c (WIDTH each);
  - outputs: next_acc (WIDTH) and step_ovf.
  - Instantiated once and shared across all steps.
- Control FSM and registers live in poly_eval_stream. There is no separate control/datapath split.

Test Plan (WIDTH=8, MAX_DEGREE=3):
- Basic: x=3, degree=2, coefficients 2,3,4 streamed back-to-back, out_ready=1 -> result 0x1F (31), overflow=0; out_valid rises 1 cycle after the 4th beat.
- Overflow: x=16, degree=2, coefficients 1,0,0 -> result 0x00, overflow=1. Then x=2, degree=1, coefficients 1,1 -> result 0x03, overflow=0, showing ovf cleared between transactions.
- Degree 0 / clamp:
  - x=5, degree=0, coefficient 7 -> result 7.
  - x=1, degree=3, coefficients 1,1,1,1 -> result 4.
  - Bench variant with MAX_DEGREE=2 and degree field 3 -> clamped to 2; the 4th beat is consumed as the next x.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid -> out_valid, result and overflow stable; in_ready=0; in_valid beats are not consumed. Release -> in_ready=1 next cycle.
- Gaps and reset: random in_valid gaps on test 1 -> same result 31. Assert resetn=0 after 2 coefficients -> next cycle busy=0, out_valid=0, in_ready=1; a fresh transaction evaluates correctly.

Source files
------------

// File: rtl/poly_eval_pkg.sv
// Shared definitions for the streaming polynomial evaluator: FSM state
// encoding, degree-field width derivation and degree clamping.
package poly_eval_pkg;

  // Controller states; two bits cover all three.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_COEF = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // Width of the degree field: enough bits to hold 0..max_degree, never 0.
  function automatic int calc_dw(input int max_degree);
    int w;
    w = $clog2(max_degree + 32'sd1);
    if (w < 32'sd1) begin
      w = 32'sd1;
    end else begin
      w = w;
    end
    return w;
  endfunction

  // Limit a requested degree to the largest degree the instance supports.
  function automatic int clamp_degree(input int degree, input int max_degree);
    int d;
    if (degree > max_degree) begin
      d = max_degree;
    end else begin
      d = degree;
    end
    return d;
  endfunction

endpackage

// File: rtl/horner_step.sv
// One Horner multiply-accumulate step: acc*x + c, reduced to WIDTH bits,
// with a flag raised when any bit above WIDTH is set.
module horner_step #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] acc,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] c,
  output logic [WIDTH-1:0] next_acc,
  output logic             step_ovf
);

  // Full-precision result: product needs 2*WIDTH bits, the add one more.
  localparam int FW = 2 * WIDTH + 1;

  logic [FW-1:0] w_full;

  assign w_full   = FW'(acc) * FW'(x) + FW'(c);
  assign next_acc = w_full[WIDTH-1:0];
  assign step_ovf = |w_full[FW-1:WIDTH];

endmodule

// File: rtl/poly_eval_stream.sv
// Streaming polynomial evaluator. The first accepted beat carries x and the
// degree; the following beats carry coefficients, highest order first, and
// each one is folded into the accumulator with a single Horner step. The
// result is then offered on a valid/ready output until the consumer takes it.
module poly_eval_stream
  import poly_eval_pkg::*;
#(
  parameter  int WIDTH      = 8,
  parameter  int MAX_DEGREE = 3,
  localparam int DW         = calc_dw(MAX_DEGREE)
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [DW-1:0]    in_degree,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic             out_overflow,
  output logic             busy
);

  state_t           r_state;
  logic [WIDTH-1:0] r_x;
  logic [WIDTH-1:0] r_acc;
  logic             r_ovf;
  logic [DW-1:0]    r_deg;
  logic [DW-1:0]    r_count;
  logic             r_in_ready;
  logic             r_out_valid;
  logic             r_busy;
  logic [WIDTH-1:0] r_out_result;
  logic             r_out_overflow;

  logic             w_accept;
  logic [DW-1:0]    w_deg_clamped;
  logic [WIDTH-1:0] w_next_acc;
  logic             w_step_ovf;
  logic             w_ovf_sum;

  // in_ready is a register, so acceptance never depends combinationally on
  // anything the source can change within the cycle.
  assign w_accept      = in_valid && r_in_ready;
  assign w_deg_clamped = DW'(clamp_degree(int'(in_degree), MAX_DEGREE));
  assign w_ovf_sum     = r_ovf | w_step_ovf;

  // Single shared multiply-accumulate; on the first coefficient acc is 0,
  // so the step simply loads c_n.
  horner_step #(
    .WIDTH(WIDTH)
  ) u_horner_step (
    .acc      (r_acc),
    .x        (r_x),
    .c        (in_data),
    .next_acc (w_next_acc),
    .step_ovf (w_step_ovf)
  );

  // Controller and datapath registers, including every registered output.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state        <= S_IDLE;
      r_x            <= '0;
      r_acc          <= '0;
      r_ovf          <= 1'b0;
      r_deg          <= '0;
      r_count        <= '0;
      r_in_ready     <= 1'b1;
      r_out_valid    <= 1'b0;
      r_busy         <= 1'b0;
      r_out_result   <= '0;
      r_out_overflow <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_x     <= in_data;
            r_deg   <= w_deg_clamped;
            r_count <= '0;
            r_acc   <= '0;
            r_ovf   <= 1'b0;
            r_busy  <= 1'b1;
            r_state <= S_COEF;
          end else begin
            r_state <= S_IDLE;
          end
        end

        S_COEF: begin
          if (w_accept) begin
            r_acc <= w_next_acc;
            r_ovf <= w_ovf_sum;
            if (r_count == r_deg) begin
              // Last coefficient: present the result from the next cycle on.
              r_out_result   <= w_next_acc;
              r_out_overflow <= w_ovf_sum;
              r_out_valid    <= 1'b1;
              r_in_ready     <= 1'b0;
              r_state        <= S_DONE;
            end else begin
              r_count <= r_count + DW'(1'b1);
            end
          end else begin
            // Source gap: everything holds.
            r_state <= S_COEF;
          end
        end

        S_DONE: begin
          // Input beats are ignored here; only the output handshake moves on.
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_busy      <= 1'b0;
            r_state     <= S_IDLE;
          end else begin
            r_state <= S_DONE;
          end
        end

        default: begin
          r_out_valid <= 1'b0;
          r_in_ready  <= 1'b1;
          r_busy      <= 1'b0;
          r_state     <= S_IDLE;
        end
      endcase
    end
  end

  assign in_ready     = r_in_ready;
  assign out_valid    = r_out_valid;
  assign out_result   = r_out_result;
  assign out_overflow = r_out_overflow;
  assign busy         = r_busy;

endmodule

// File: tb/tb_poly_eval_stream.sv
// Bench for poly_eval_stream: directed transactions, expected results
// queued at issue time and compared by independent output monitors.
module tb_poly_eval_stream;

  logic       clk;
  logic       resetn;

  // Instance A: WIDTH=8, MAX_DEGREE=3
  logic       a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_out_overflow, a_busy;
  logic [7:0] a_in_data, a_out_result;
  logic [1:0] a_in_degree;

  // Instance B: WIDTH=8, MAX_DEGREE=2 (clamp variant)
  logic       b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_out_overflow, b_busy;
  logic [7:0] b_in_data, b_out_result;
  logic [1:0] b_in_degree;

  int checks = 0;
  int errors = 0;

  logic [8:0] qa[$];
  logic [8:0] qb[$];
  logic [8:0] exp_a;
  logic [8:0] exp_b;

  poly_eval_stream #(.WIDTH(8), .MAX_DEGREE(3)) dut_a (
    .clk(clk), .resetn(resetn),
    .in_valid(a_in_valid), .in_ready(a_in_ready),
    .in_data(a_in_data), .in_degree(a_in_degree),
    .out_valid(a_out_valid), .out_ready(a_out_ready),
    .out_result(a_out_result), .out_overflow(a_out_overflow),
    .busy(a_busy)
  );

  poly_eval_stream #(.WIDTH(8), .MAX_DEGREE(2)) dut_b (
    .clk(clk), .resetn(resetn),
    .in_valid(b_in_valid), .in_ready(b_in_ready),
    .in_data(b_in_data), .in_degree(b_in_degree),
    .out_valid(b_out_valid), .out_ready(b_out_ready),
    .out_result(b_out_result), .out_overflow(b_out_overflow),
    .busy(b_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Present one beat and hold it until the DUT accepts it (bounded).
  task automatic push(input bit sel, input logic [7:0] d, input logic [1:0] deg);
    int n;
    n = 0;
    if (sel) begin
      b_in_valid = 1'b1; b_in_data = d; b_in_degree = deg;
    end else begin
      a_in_valid = 1'b1; a_in_data = d; a_in_degree = deg;
    end
    while (!(sel ? b_in_ready : a_in_ready) && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= 50) begin
      checks++;
      errors++;
      $display("FAIL push_timeout sel=%0d actual=in_ready_low required=accept", sel);
    end
    @(posedge clk);
    #1;
    if (sel) b_in_valid = 1'b0;
    else a_in_valid = 1'b0;
  endtask

  // Output monitor for instance A.
  always @(negedge clk) begin
    if (resetn && a_out_valid && a_out_ready) begin
      checks++;
      if (qa.size() == 0) begin
        errors++;
        $display("FAIL a_unexpected_result actual=%0h required=none", {a_out_overflow, a_out_result});
      end else begin
        exp_a = qa.pop_front();
        if ({a_out_overflow, a_out_result} !== exp_a) begin
          errors++;
          $display("FAIL a_result actual=ovf%0d/%0h required=ovf%0d/%0h",
                   a_out_overflow, a_out_result, exp_a[8], exp_a[7:0]);
        end
      end
    end
  end

  // Output monitor for instance B.
  always @(negedge clk) begin
    if (resetn && b_out_valid && b_out_ready) begin
      checks++;
      if (qb.size() == 0) begin
        errors++;
        $display("FAIL b_unexpected_result actual=%0h required=none", {b_out_overflow, b_out_result});
      end else begin
        exp_b = qb.pop_front();
        if ({b_out_overflow, b_out_result} !== exp_b) begin
          errors++;
          $display("FAIL b_result actual=ovf%0d/%0h required=ovf%0d/%0h",
                   b_out_overflow, b_out_result, exp_b[8], exp_b[7:0]);
        end
      end
    end
  end

  initial begin
    int n;
    resetn = 1'b0;
    a_in_valid = 1'b0; a_in_data = 8'd0; a_in_degree = 2'd0; a_out_ready = 1'b1;
    b_in_valid = 1'b0; b_in_data = 8'd0; b_in_degree = 2'd0; b_out_ready = 1'b1;
    idle(2);

    // Reset state
    chk("rst_in_ready", a_in_ready, 1);
    chk("rst_out_valid", a_out_valid, 0);
    chk("rst_out_result", a_out_result, 0);
    chk("rst_out_overflow", a_out_overflow, 0);
    chk("rst_busy", a_busy, 0);
    resetn = 1'b1;
    idle(1);

    // Basic: 2x^2+3x+4 at x=3 = 31
    qa.push_back({1'b0, 8'd31});
    push(0, 8'd3, 2'd2);
    chk("busy_after_x", a_busy, 1);
    push(0, 8'd2, 2'd0);
    push(0, 8'd3, 2'd0);
    push(0, 8'd4, 2'd0);
    chk("basic_latency", a_out_valid, 1);
    chk("basic_in_ready_done", a_in_ready, 0);
    idle(2);

    // Overflow: x^2 at x=16 = 256 -> 0 with overflow
    qa.push_back({1'b1, 8'd0});
    push(0, 8'd16, 2'd2);
    push(0, 8'd1, 2'd0);
    push(0, 8'd0, 2'd0);
    push(0, 8'd0, 2'd0);
    idle(1);
    // x+1 at x=2 = 3, overflow cleared
    qa.push_back({1'b0, 8'd3});
    push(0, 8'd2, 2'd1);
    push(0, 8'd1, 2'd0);
    push(0, 8'd1, 2'd0);
    idle(1);
    // 2x+1 at x=255 = 511 -> 0xFF with overflow
    qa.push_back({1'b1, 8'hFF});
    push(0, 8'd255, 2'd1);
    push(0, 8'd2, 2'd0);
    push(0, 8'd1, 2'd0);
    idle(1);

    // Degree 0: result is c_0
    qa.push_back({1'b0, 8'd7});
    push(0, 8'd5, 2'd0);
    push(0, 8'd7, 2'd0);
    chk("deg0_latency", a_out_valid, 1);
    idle(1);

    // Full degree: x^3+x^2+x+1 at x=1 = 4
    qa.push_back({1'b0, 8'd4});
    push(0, 8'd1, 2'd3);
    repeat (4) push(0, 8'd1, 2'd0);
    idle(1);

    // Clamp on MAX_DEGREE=2: degree 3 -> 2; x^2+x+1 at x=2 = 7,
    // then the 4th beat (3) is the next x with degree 0, coefficient 9.
    qb.push_back({1'b0, 8'd7});
    qb.push_back({1'b0, 8'd9});
    push(1, 8'd2, 2'd3);
    push(1, 8'd1, 2'd0);
    push(1, 8'd1, 2'd0);
    push(1, 8'd1, 2'd0);
    chk("clamp_done", b_out_valid, 1);
    push(1, 8'd3, 2'd0);
    push(1, 8'd9, 2'd0);
    idle(1);

    // Backpressure: hold the result, ignore input beats
    a_out_ready = 1'b0;
    qa.push_back({1'b0, 8'd31});
    push(0, 8'd3, 2'd2);
    push(0, 8'd2, 2'd0);
    push(0, 8'd3, 2'd0);
    push(0, 8'd4, 2'd0);
    a_in_valid = 1'b1; a_in_data = 8'd2; a_in_degree = 2'd1;
    for (int i = 0; i < 5; i++) begin
      chk("bp_out_valid", a_out_valid, 1);
      chk("bp_result", a_out_result, 31);
      chk("bp_overflow", a_out_overflow, 0);
      chk("bp_in_ready", a_in_ready, 0);
      idle(1);
    end
    // Release with in_valid still high: only the output handshake completes
    qa.push_back({1'b0, 8'd3});
    a_out_ready = 1'b1;
    idle(1);
    chk("release_in_ready", a_in_ready, 1);
    chk("release_out_valid", a_out_valid, 0);
    push(0, 8'd2, 2'd1);
    push(0, 8'd1, 2'd0);
    push(0, 8'd1, 2'd0);
    idle(1);

    // Random gaps on the basic transaction
    qa.push_back({1'b0, 8'd31});
    idle($urandom_range(0, 3)); push(0, 8'd3, 2'd2);
    idle($urandom_range(0, 3)); push(0, 8'd2, 2'd0);
    idle($urandom_range(0, 3)); push(0, 8'd3, 2'd0);
    idle($urandom_range(0, 3)); push(0, 8'd4, 2'd0);
    idle(2);

    // Reset after two coefficients
    push(0, 8'd3, 2'd2);
    push(0, 8'd2, 2'd0);
    push(0, 8'd3, 2'd0);
    chk("pre_reset_busy", a_busy, 1);
    resetn = 1'b0;
    idle(1);
    resetn = 1'b1;
    chk("midrst_busy", a_busy, 0);
    chk("midrst_out_valid", a_out_valid, 0);
    chk("midrst_in_ready", a_in_ready, 1);
    // Fresh: x^3+2x^2+3x+4 at x=4 = 112
    qa.push_back({1'b0, 8'h70});
    push(0, 8'd4, 2'd3);
    push(0, 8'd1, 2'd0);
    push(0, 8'd2, 2'd0);
    push(0, 8'd3, 2'd0);
    push(0, 8'd4, 2'd0);
    idle(1);

    // Reset while holding a result
    a_out_ready = 1'b0;
    push(0, 8'd5, 2'd0);
    push(0, 8'd7, 2'd0);
    chk("done_before_rst", a_out_valid, 1);
    resetn = 1'b0;
    idle(1);
    resetn = 1'b1;
    chk("donerst_out_valid", a_out_valid, 0);
    chk("donerst_in_ready", a_in_ready, 1);
    a_out_ready = 1'b1;

    // Drain scoreboards
    n = 0;
    while ((qa.size() != 0 || qb.size() != 0) && n < 200) begin
      idle(1);
      n++;
    end
    if (qa.size() != 0 || qb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain actual=%0d/%0d pending required=0/0", qa.size(), qb.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
